q_frag_bank: RTL and testbench

//  Bank of N logic-cell output registers sitting directly downstream of the T_FRAG

---
 rtl/q_frag_pkg.sv | 16 +
 rtl/q_frag_cell.sv | 44 ++++
 rtl/q_frag_bank.sv | 135 +++++++++++++
 tb/tb_q_frag_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/q_frag_pkg.sv
// Shared types and helpers for the Q_FRAG register bank.
// State encoding, cell-count bound and preload counter width.
package q_frag_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        SHIFT = 1'b1
    } q_state_t;

    localparam int Q_FRAG_MAX_CELLS = 32;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/q_frag_cell.sv
// One Q_FRAG output register.
// Provides the clear/set/enable/select mux, the preload shift-in path and the flop.
module q_frag_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic shift_en,
    input  logic shift_in,
    input  logic qrt,
    input  logic qst,
    input  logic qen,
    input  logic qds,
    input  logic qdi,
    input  logic cz,
    output logic q
);

    logic q_reg;
    logic q_next;

    // The shift path overrides every functional control while a preload is running.
    always_comb begin
        q_next = q_reg;
        if (shift_en) begin
            q_next = shift_in;
        end else if (qrt) begin
            q_next = 1'b0;
        end else if (qst) begin
            q_next = 1'b1;
        end else if (qen) begin
            q_next = qds ? qdi : cz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= 1'b0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/q_frag_bank.sv
// Bank of N_CELLS Q_FRAG output registers with a serial preload path.
// Define Q_FRAG_READBACK_EN to add the RB_DATA/RB_VALID readback of the displaced word.
module q_frag_bank
    import q_frag_pkg::*;
#(
    parameter int N_CELLS = 4
) (
    input  logic               QCK,
    input  logic               QRN,
    input  logic [N_CELLS-1:0] CZ,
    input  logic [N_CELLS-1:0] QDI,
    input  logic [N_CELLS-1:0] QDS,
    input  logic               QEN,
    input  logic               QST,
    input  logic               QRT,
    input  logic               LD_VALID,
    input  logic [N_CELLS-1:0] LD_DATA,
    output logic               LD_READY,
    output logic [N_CELLS-1:0] QZ
`ifdef Q_FRAG_READBACK_EN
    ,
    output logic [N_CELLS-1:0] RB_DATA,
    output logic               RB_VALID
`endif
);

    localparam int CW = cnt_w(N_CELLS);
    localparam logic [CW-1:0] LAST = CW'(N_CELLS - 1);

    q_state_t           state_reg, state_next;
    logic [CW-1:0]      count_reg, count_next;
    logic [N_CELLS-1:0] shadow_reg, shadow_next;
    logic               shift_en;
    logic [N_CELLS-1:0] shift_in;

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        shadow_next = shadow_reg;
        shift_en    = 1'b0;
        case (state_reg)
            RUN: begin
                if (LD_VALID) begin
                    shadow_next = LD_DATA;
                    count_next  = '0;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                shift_en    = 1'b1;
                shadow_next = shadow_reg << 1;
                count_next  = count_reg + CW'(1);
                if (count_reg == LAST) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge QCK or negedge QRN) begin
        if (!QRN) begin
            state_reg  <= RUN;
            count_reg  <= '0;
            shadow_reg <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            shadow_reg <= shadow_next;
        end
    end

    assign LD_READY = (state_reg == RUN);

    // Cell 0 takes the shadow MSB; each higher cell takes its lower neighbour.
    generate
        for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
            if (gi == 0) begin : g_head
                assign shift_in[gi] = shadow_reg[N_CELLS-1];
            end else begin : g_link
                assign shift_in[gi] = QZ[gi-1];
            end

            q_frag_cell u_cell (
                .clk      (QCK),
                .rst_n    (QRN),
                .shift_en (shift_en),
                .shift_in (shift_in[gi]),
                .qrt      (QRT),
                .qst      (QST),
                .qen      (QEN),
                .qds      (QDS[gi]),
                .qdi      (QDI[gi]),
                .cz       (CZ[gi]),
                .q        (QZ[gi])
            );
        end
    endgenerate

`ifdef Q_FRAG_READBACK_EN
    logic [N_CELLS-1:0] rb_shift_reg;
    logic [N_CELLS-1:0] rb_shift_next;
    logic               last_shift;

    assign last_shift = shift_en && (count_reg == LAST);

    // Collect bits leaving the top cell privately so RB_DATA only changes on completion.
    generate
        for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_rb
            if (gi == 0) begin : g_head
                assign rb_shift_next[gi] = QZ[N_CELLS-1];
            end else begin : g_link
                assign rb_shift_next[gi] = rb_shift_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge QCK or negedge QRN) begin
        if (!QRN) begin
            rb_shift_reg <= '0;
            RB_DATA      <= '0;
            RB_VALID     <= 1'b0;
        end else begin
            if (shift_en) begin
                rb_shift_reg <= rb_shift_next;
            end
            if (last_shift) begin
                RB_DATA <= rb_shift_next;
            end
            RB_VALID <= last_shift;
        end
    end
`endif

endmodule

// File: tb/tb_q_frag_bank.sv
// Self-checking bench for q_frag_bank: directed steps plus randomized run/load traffic
// against a word-level model; covers N_CELLS=4 and N_CELLS=1.
module tb_q_frag_bank;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cz = '0, qdi = '0, qds = '0, ld_data = '0;
    logic       qen = 1'b0, qst = 1'b0, qrt = 1'b0, ld_valid = 1'b0;
    logic       ld_ready;
    logic [3:0] qz;

    logic       ld_valid1 = 1'b0;
    logic [0:0] ld_data1 = '0;
    logic       ld_ready1;
    logic [0:0] qz1;

`ifdef Q_FRAG_READBACK_EN
    logic [3:0] rb_data;
    logic       rb_valid;
    logic [0:0] rb_data1;
    logic       rb_valid1;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_qz = '0;
    logic [3:0] exp_rb = '0;

    always #5 clk = ~clk;

    q_frag_bank #(.N_CELLS(N)) u_dut (
        .QCK      (clk),
        .QRN      (rst_n),
        .CZ       (cz),
        .QDI      (qdi),
        .QDS      (qds),
        .QEN      (qen),
        .QST      (qst),
        .QRT      (qrt),
        .LD_VALID (ld_valid),
        .LD_DATA  (ld_data),
        .LD_READY (ld_ready),
        .QZ       (qz)
`ifdef Q_FRAG_READBACK_EN
        ,
        .RB_DATA  (rb_data),
        .RB_VALID (rb_valid)
`endif
    );

    q_frag_bank #(.N_CELLS(1)) u_dut1 (
        .QCK      (clk),
        .QRN      (rst_n),
        .CZ       (1'b0),
        .QDI      (1'b0),
        .QDS      (1'b0),
        .QEN      (1'b0),
        .QST      (1'b0),
        .QRT      (1'b0),
        .LD_VALID (ld_valid1),
        .LD_DATA  (ld_data1),
        .LD_READY (ld_ready1),
        .QZ       (qz1)
`ifdef Q_FRAG_READBACK_EN
        ,
        .RB_DATA  (rb_data1),
        .RB_VALID (rb_valid1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word-level RUN rule: clear beats set beats enable; QDS picks QDI over CZ per bit.
    function automatic logic [3:0] run_rule(input logic [3:0] cur);
        if (qrt)      return 4'h0;
        else if (qst) return 4'hF;
        else if (qen) return (qdi & qds) | (cz & ~qds);
        else          return cur;
    endfunction

    task automatic load(input logic [3:0] data, input bit disturb, input bit hold_valid);
        ld_valid = 1'b1;
        ld_data  = data;
        exp_qz   = run_rule(exp_qz);
        exp_rb   = exp_qz;
        tick();
        if (!hold_valid) ld_valid = 1'b0;
        chk("ld_ready_accept", 32'(ld_ready), 32'h0);
        for (int k = 1; k <= N; k++) begin
            if (disturb) begin
                {qrt, qst, qen} = 3'($urandom);
                cz      = 4'($urandom);
                qdi     = 4'($urandom);
                qds     = 4'($urandom);
                ld_data = 4'($urandom);
            end
            tick();
            if (k < N) chk("ld_ready_shift", 32'(ld_ready), 32'h0);
        end
        exp_qz = data;
        chk("load_qz", 32'(qz), 32'(exp_qz));
        chk("ld_ready_done", 32'(ld_ready), 32'h1);
`ifdef Q_FRAG_READBACK_EN
        chk("rb_valid_pulse", 32'(rb_valid), 32'h1);
        chk("rb_data", 32'(rb_data), 32'(exp_rb));
`endif
        {qrt, qst, qen} = 3'b000;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("reset_qz", 32'(qz), 32'h0);
        chk("reset_ld_ready", 32'(ld_ready), 32'h1);
        chk("reset_qz1", 32'(qz1), 32'h0);
`ifdef Q_FRAG_READBACK_EN
        chk("reset_rb_data", 32'(rb_data), 32'h0);
        chk("reset_rb_valid", 32'(rb_valid), 32'h0);
`endif
        rst_n = 1'b1;

        // Data path select
        qds = 4'b0011; qdi = 4'b0001; cz = 4'b1010; qen = 1'b1;
        exp_qz = run_rule(exp_qz);
        tick();
        chk("datapath", 32'(qz), 32'(exp_qz));
        qen = 1'b0; cz = 4'b0101; qdi = 4'b1110;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold", 32'(qz), 32'(exp_qz));
        end

        // Priority
        qrt = 1'b1; qst = 1'b1; qen = 1'b1;
        exp_qz = run_rule(exp_qz);
        tick();
        chk("prio_clear", 32'(qz), 32'(exp_qz));
        qrt = 1'b0;
        exp_qz = run_rule(exp_qz);
        tick();
        chk("prio_set", 32'(qz), 32'(exp_qz));

        // Preload 1100 over 0110
        qst = 1'b0; qen = 1'b1; qds = 4'hF; qdi = 4'b0110;
        exp_qz = run_rule(exp_qz);
        tick();
        chk("pre_qz", 32'(qz), 32'(exp_qz));
        qen = 1'b0;
        load(4'b1100, 1'b0, 1'b0);
        tick();
        chk("post_load_hold", 32'(qz), 32'(exp_qz));
`ifdef Q_FRAG_READBACK_EN
        chk("rb_valid_drop", 32'(rb_valid), 32'h0);
        chk("rb_data_hold", 32'(rb_data), 32'(exp_rb));
`endif

        // Disturbed load, then LD_VALID held across two loads
        load(4'($urandom), 1'b1, 1'b0);
        load(4'b1010, 1'b0, 1'b1);
        load(4'b0101, 1'b0, 1'b0);

        // Abort with reset at shift 2
        ld_valid = 1'b1; ld_data = 4'($urandom);
        tick();
        ld_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_qz", 32'(qz), 32'h0);
        chk("abort_ld_ready", 32'(ld_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        exp_qz = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_hold_qz", 32'(qz), 32'h0);
`ifdef Q_FRAG_READBACK_EN
            chk("abort_no_rb_valid", 32'(rb_valid), 32'h0);
`endif
        end

        // N_CELLS=1 instance
        ld_valid1 = 1'b1; ld_data1 = 1'b1;
        tick();
        ld_valid1 = 1'b0; ld_data1 = 1'b0;
        chk("n1_ld_ready_low", 32'(ld_ready1), 32'h0);
        tick();
        chk("n1_qz", 32'(qz1), 32'h1);
        chk("n1_ld_ready_back", 32'(ld_ready1), 32'h1);
`ifdef Q_FRAG_READBACK_EN
        chk("n1_rb_valid", 32'(rb_valid1), 32'h1);
        chk("n1_rb_data", 32'(rb_data1), 32'h0);
        tick();
        chk("n1_rb_valid_drop", 32'(rb_valid1), 32'h0);
`endif

        // Randomized run edges and loads
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                load(4'($urandom), 1'b1, 1'b0);
            end else begin
                qrt = ($urandom_range(0, 5) == 0);
                qst = ($urandom_range(0, 4) == 0);
                qen = 1'($urandom);
                cz  = 4'($urandom);
                qdi = 4'($urandom);
                qds = 4'($urandom);
                exp_qz = run_rule(exp_qz);
                tick();
                chk("rand_run", 32'(qz), 32'(exp_qz));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
